// File: rtl/coconut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coconut_pkg
// Description : Shared state encoding and sizing helper for coconut_search.
// Revision    : 1.0 - initial release
// ============================================================================
package coconut_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STEP   = 3'd1,
      S_NEXT   = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } coconut_state_t;

   // Bits needed to index N night divisions plus the morning division.
   function automatic int idx_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/coconut_search_if.sv
`default_nettype none
// ============================================================================
// Module      : coconut_search_if
// Description : Command/status and share-stream bundle for coconut_search.
// Revision    : 1.0 - initial release
// ============================================================================
interface coconut_search_if
   import coconut_pkg::*;
#(
   parameter int W     = 32,
   parameter int N_MEN = 5
);
   localparam int IDX_W = idx_width(N_MEN);

   logic             start;
   logic [W-1:0]     start_count;
   logic [W-1:0]     max_count;
   logic             busy;
   logic             done;
   logic             found;
   logic [W-1:0]     result;
   logic             share_valid;
   logic             share_ready;
   logic [W-1:0]     share_data;
   logic [IDX_W-1:0] share_idx;

   modport master (
      output start, start_count, max_count, share_ready,
      input  busy, done, found, result, share_valid, share_data, share_idx
   );

   modport slave (
      input  start, start_count, max_count, share_ready,
      output busy, done, found, result, share_valid, share_data, share_idx
   );

endinterface
`default_nettype wire

// File: rtl/coconut_div_step.sv
`default_nettype none
// ============================================================================
// Module      : coconut_div_step
// Description : One division of the pile: monkey check, share and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module coconut_div_step #(
   parameter int N_MEN  = 5,
   parameter int MONKEY = 1,
   parameter int W      = 32
) (
   input  wire logic [W-1:0] pile,
   output logic              pass,
   output logic [W-1:0]      share,
   output logic [W-1:0]      next_pile
);
   localparam logic [W-1:0] c_n_men  = W'(N_MEN);
   localparam logic [W-1:0] c_monkey = W'(MONKEY);

   logic [W-1:0] w_after_monkey;

   always_comb begin
      pass           = (pile % c_n_men) == c_monkey;
      w_after_monkey = pile - c_monkey;
      share          = w_after_monkey / c_n_men;
      next_pile      = w_after_monkey - share;
   end

endmodule
`default_nettype wire

// File: rtl/coconut_search.sv
`default_nettype none
// ============================================================================
// Module      : coconut_search
// Description : Upward search for the smallest pile surviving N_MEN+1 divisions.
// Revision    : 1.0 - initial release
// ============================================================================
module coconut_search
   import coconut_pkg::*;
#(
   parameter int N_MEN  = 5,
   parameter int MONKEY = 1,
   parameter int W      = 32
) (
   input  wire logic        clk,
   input  wire logic        reset,
   coconut_search_if.slave  bus
);
   localparam int               IDX_W        = idx_width(N_MEN);
   localparam logic [IDX_W-1:0] c_last_round = IDX_W'(N_MEN);
   localparam logic [W-1:0]     c_final_min  = W'(N_MEN + MONKEY);

   coconut_state_t   r_state;
   logic [W-1:0]     r_cand;
   logic [W-1:0]     r_pile;
   logic [W-1:0]     r_max;
   logic [IDX_W-1:0] r_round;
   logic [W-1:0]     r_share [0:N_MEN];

   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic [W-1:0]     r_result;
   logic             r_share_valid;
   logic [W-1:0]     r_share_data;
   logic [IDX_W-1:0] r_share_idx;

   logic             w_pass;
   logic [W-1:0]     w_share;
   logic [W-1:0]     w_next_pile;
   logic             w_last;
   logic             w_accept;

   coconut_div_step #(
      .N_MEN  (N_MEN),
      .MONKEY (MONKEY),
      .W      (W)
   ) u_div_step (
      .pile      (r_pile),
      .pass      (w_pass),
      .share     (w_share),
      .next_pile (w_next_pile)
   );

   // The morning division must also leave every sailor at least one coconut.
   assign w_last   = (r_round == c_last_round);
   assign w_accept = w_pass && (!w_last || (r_pile >= c_final_min));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cand        <= '0;
         r_pile        <= '0;
         r_max         <= '0;
         r_round       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_found       <= 1'b0;
         r_result      <= '0;
         r_share_valid <= 1'b0;
         r_share_data  <= '0;
         r_share_idx   <= '0;
         for (int i = 0; i <= N_MEN; i++) begin
            r_share[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy  <= 1'b1;
                  r_found <= 1'b0;
                  if (bus.start_count > bus.max_count) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cand  <= bus.start_count;
                     r_pile  <= bus.start_count;
                     r_max   <= bus.max_count;
                     r_round <= '0;
                     r_state <= S_STEP;
                  end
               end
            end
            S_STEP: begin
               if (w_accept) begin
                  r_share[r_round] <= w_share;
                  if (w_last) begin
                     r_found       <= 1'b1;
                     r_result      <= r_cand;
                     r_share_valid <= 1'b1;
                     r_share_data  <= r_share[0];
                     r_share_idx   <= '0;
                     r_state       <= S_STREAM;
                  end else begin
                     r_pile  <= w_next_pile;
                     r_round <= r_round + IDX_W'(1);
                  end
               end else begin
                  r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (r_cand == r_max) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cand  <= r_cand + W'(1);
                  r_pile  <= r_cand + W'(1);
                  r_round <= '0;
                  r_state <= S_STEP;
               end
            end
            S_STREAM: begin
               if (bus.share_ready) begin
                  if (r_share_idx == c_last_round) begin
                     r_share_valid <= 1'b0;
                     r_done        <= 1'b1;
                     r_state       <= S_DONE;
                  end else begin
                     r_share_idx  <= r_share_idx + IDX_W'(1);
                     r_share_data <= r_share[r_share_idx + IDX_W'(1)];
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.found       = r_found;
   assign bus.result      = r_result;
   assign bus.share_valid = r_share_valid;
   assign bus.share_data  = r_share_data;
   assign bus.share_idx   = r_share_idx;

endmodule
`default_nettype wire

// File: tb/tb_coconut_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_coconut_search
// Description : Directed self-checking bench for coconut_search (5 and 3 sailors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coconut_search;

   logic clk;
   logic reset;

   int n_checks;
   int n_pass;

   logic [31:0] got_d [0:7];
   logic [2:0]  got_i [0:7];
   int          n_got;
   int          valid_seen;

   coconut_search_if #(.W(32), .N_MEN(5)) bus5 ();
   coconut_search_if #(.W(32), .N_MEN(3)) bus3 ();

   coconut_search #(.N_MEN(5), .MONKEY(1), .W(32)) dut5 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus5)
   );

   coconut_search #(.N_MEN(3), .MONKEY(1), .W(32)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start5(input logic [31:0] s, input logic [31:0] m);
      @(negedge clk);
      bus5.start       = 1'b1;
      bus5.start_count = s;
      bus5.max_count   = m;
      @(negedge clk);
      bus5.start       = 1'b0;
   endtask

   // Waits for done on the 5-sailor DUT, capturing transfers; optionally
   // withholds ready for stall_n cycles when index stall_idx is presented.
   task automatic collect5(input int stall_idx, input int stall_n, input int limit,
                           output int cyc);
      int          stalled;
      logic [31:0] held_d;
      logic [2:0]  held_i;
      cyc        = 0;
      stalled    = 0;
      n_got      = 0;
      valid_seen = 0;
      held_d     = '0;
      held_i     = '0;
      bus5.share_ready = 1'b1;
      while (!bus5.done && cyc < limit) begin
         if (bus5.share_valid) begin
            valid_seen++;
            if (int'(bus5.share_idx) == stall_idx && stalled < stall_n) begin
               if (stalled == 0) begin
                  held_d = bus5.share_data;
                  held_i = bus5.share_idx;
               end else begin
                  check("stall_data", bus5.share_data, held_d);
                  check("stall_idx", bus5.share_idx, held_i);
               end
               bus5.share_ready = 1'b0;
               stalled++;
            end else begin
               if (stall_n > 0 && int'(bus5.share_idx) == stall_idx) begin
                  check("stall_release_data", bus5.share_data, held_d);
               end
               bus5.share_ready = 1'b1;
               if (n_got < 8) begin
                  got_d[n_got] = bus5.share_data;
                  got_i[n_got] = bus5.share_idx;
               end
               n_got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      check("done_timeout", (cyc >= limit), 0);
      bus5.share_ready = 1'b1;
   endtask

   task automatic check_found5();
      logic [31:0] exp_sh [0:5];
      exp_sh[0] = 32'd3124;
      exp_sh[1] = 32'd2499;
      exp_sh[2] = 32'd1999;
      exp_sh[3] = 32'd1599;
      exp_sh[4] = 32'd1279;
      exp_sh[5] = 32'd1023;
      check("found", bus5.found, 1);
      check("result", bus5.result, 32'd15621);
      check("n_transfers", n_got, 6);
      for (int i = 0; i < 6 && i < n_got; i++) begin
         check("share_data", got_d[i], exp_sh[i]);
         check("share_idx", got_i[i], i);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bus5.busy, 0);
      check({tag, "_done"}, bus5.done, 0);
      check({tag, "_found"}, bus5.found, 0);
      check({tag, "_result"}, bus5.result, 0);
      check({tag, "_valid"}, bus5.share_valid, 0);
      check({tag, "_data"}, bus5.share_data, 0);
      check({tag, "_idx"}, bus5.share_idx, 0);
   endtask

   initial begin
      int          cyc_a;
      int          cyc_b;
      int          cyc;
      int          n3;
      logic [31:0] d3 [0:3];
      logic [31:0] exp3 [0:3];

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      bus5.start = 1'b0; bus5.start_count = '0; bus5.max_count = '0; bus5.share_ready = 1'b1;
      bus3.start = 1'b0; bus3.start_count = '0; bus3.max_count = '0; bus3.share_ready = 1'b1;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      // Classic five sailors from candidate 1.
      start5(32'd1, 32'd20000);
      check("busy_after_start", bus5.busy, 1);
      collect5(-1, 0, 60000, cyc);
      check_found5();
      @(negedge clk);
      check("busy_after_done", bus5.busy, 0);
      check("done_pulse_len", bus5.done, 0);

      // Range past the only solution below 20000.
      start5(32'd15622, 32'd20000);
      collect5(-1, 0, 20000, cyc);
      check("nf_found", bus5.found, 0);
      check("nf_valid_seen", valid_seen, 0);
      @(negedge clk);

      // Backpressure: compare done latency with and without a 3-cycle stall.
      start5(32'd15000, 32'd20000);
      collect5(-1, 0, 5000, cyc_a);
      @(negedge clk);
      start5(32'd15000, 32'd20000);
      collect5(2, 3, 5000, cyc_b);
      check_found5();
      check("stall_delay", cyc_b - cyc_a, 3);
      @(negedge clk);

      // A start while busy with a range that has no solution must be ignored.
      start5(32'd15000, 32'd20000);
      repeat (20) @(negedge clk);
      bus5.start       = 1'b1;
      bus5.start_count = 32'd15622;
      bus5.max_count   = 32'd20000;
      @(negedge clk);
      bus5.start = 1'b0;
      collect5(-1, 0, 5000, cyc);
      check("ignored_start_found", bus5.found, 1);
      check("ignored_start_result", bus5.result, 32'd15621);
      @(negedge clk);

      // Empty range: done in the cycle after start is accepted, found cleared.
      @(negedge clk);
      bus5.start       = 1'b1;
      bus5.start_count = 32'd50;
      bus5.max_count   = 32'd10;
      @(negedge clk);
      bus5.start = 1'b0;
      check("empty_done", bus5.done, 1);
      check("empty_busy", bus5.busy, 1);
      check("empty_found", bus5.found, 0);
      @(negedge clk);
      check("empty_done_clear", bus5.done, 0);
      check("empty_busy_clear", bus5.busy, 0);

      // Three sailors on the second instance.
      exp3[0] = 32'd26; exp3[1] = 32'd17; exp3[2] = 32'd11; exp3[3] = 32'd7;
      bus3.start       = 1'b1;
      bus3.start_count = 32'd1;
      bus3.max_count   = 32'd100;
      @(negedge clk);
      bus3.start = 1'b0;
      n3  = 0;
      cyc = 0;
      while (!bus3.done && cyc < 2000) begin
         if (bus3.share_valid) begin
            if (n3 < 4) d3[n3] = bus3.share_data;
            n3++;
         end
         @(negedge clk);
         cyc++;
      end
      check("n3_timeout", (cyc >= 2000), 0);
      check("n3_found", bus3.found, 1);
      check("n3_result", bus3.result, 32'd79);
      check("n3_transfers", n3, 4);
      for (int i = 0; i < 4 && i < n3; i++) begin
         check("n3_share", d3[i], exp3[i]);
      end

      // Asynchronous reset in the middle of the search.
      start5(32'd1, 32'd20000);
      repeat (50) @(negedge clk);
      check("mid_step_busy", bus5.busy, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_step");
      @(negedge clk);
      reset = 1'b0;

      // Asynchronous reset while the stream is stalled.
      start5(32'd15600, 32'd20000);
      bus5.share_ready = 1'b0;
      cyc = 0;
      while (!bus5.share_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("stream_timeout", (cyc >= 2000), 0);
      check("mid_stream_found", bus5.found, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_stream");
      @(negedge clk);
      reset = 1'b0;
      bus5.share_ready = 1'b1;

      // Fresh search after reset.
      start5(32'd15000, 32'd20000);
      collect5(-1, 0, 5000, cyc);
      check_found5();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
